mux4x1_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 4:1 bit mux among four requesters.
//  - Each requester i raises req[i] and drives its data bit on din[i].
//  - The arbiter grants one owner at a time, drives the mux select and presents the owner's bit on dout.
//  - Sits in front of the existing gate-level mux4x1, replacing a static select.

---
 rtl/mux4x1_rr_arbiter_pkg.sv | 42 ++++
 rtl/mux4x1_rr_arbiter_mux.sv | 21 ++
 rtl/mux4x1_rr_arbiter.sv | 110 +++++++++++
 tb/tb_mux4x1_rr_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mux4x1_rr_arbiter_pkg.sv
// Shared definitions for the round-robin front end of the 4:1 bit mux:
// state encodings, requester count, select width and the RR search helper.
package mux4x1_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Result of a round-robin search: whether anyone requests, and who wins.
    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First requester found scanning start, start+1, start+2, start+3 (mod 4).
    // The scan runs from the farthest offset down so the nearest hit wins.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   start);
        pick_t            p;
        logic [SEL_W-1:0] idx;
        p.found = 1'b0;
        p.idx   = start;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4x1_rr_arbiter_mux.sv
// Existing gate-level 4:1 bit multiplexer: y = din[sel].
module mux4x1 (
    input  logic [1:0] sel,
    input  logic [3:0] din,
    output logic       y
);

    logic s0_n, s1_n;
    logic t0, t1, t2, t3;

    not u_n0 (s0_n, sel[0]);
    not u_n1 (s1_n, sel[1]);

    and u_a0 (t0, din[0], s0_n,   s1_n);
    and u_a1 (t1, din[1], sel[0], s1_n);
    and u_a2 (t2, din[2], s0_n,   sel[1]);
    and u_a3 (t3, din[3], sel[0], sel[1]);

    or  u_o  (y, t0, t1, t2, t3);

endmodule

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux among four requesters.
// A grant lasts until its owner drops req or MAX_HOLD cycles elapse; the
// released owner becomes lowest priority for the next search.
// Optional feature: define RR_ARB_LOCK_EN to add a lock input that
// suppresses the hold timeout while the owner keeps requesting.
module mux4x1_rr_arbiter
    import mux4x1_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,   // legal range 1 .. 2**CNT_W
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
`ifdef RR_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               valid,
    output logic               dout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    pick_t pick_idle;   // search from the rotating pointer (leaving IDLE)
    pick_t pick_next;   // search starting just past the current owner
    logic  lock_hold;
    logic  owner_req;
    logic  timeout;
    logic  rel_grant;
    logic  raw_bit;

`ifdef RR_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign pick_idle = rr_pick(req, ptr);
    assign pick_next = rr_pick(req, sel + SEL_W'(1));
    assign owner_req = req[sel];
    // A held lock only matters while the owner still requests.
    assign timeout   = (hold_cnt == HOLD_LAST) && !(lock_hold && owner_req);
    assign rel_grant = !owner_req || timeout;

    // Arbitration FSM with registered grant, select and valid.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            valid    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_idle.found) begin
                        state    <= ARB_GRANT;
                        sel      <= pick_idle.idx;
                        gnt      <= onehot(pick_idle.idx);
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (rel_grant) begin
                        ptr      <= sel + SEL_W'(1);
                        hold_cnt <= '0;
                        if (pick_next.found) begin
                            sel <= pick_next.idx;
                            gnt <= onehot(pick_next.idx);
                        end else begin
                            state <= ARB_IDLE;
                            sel   <= '0;
                            gnt   <= '0;
                            valid <= 1'b0;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        // Saturates at HOLD_LAST while a lock defers the timeout.
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    sel   <= '0;
                    gnt   <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    mux4x1 u_mux (
        .sel (sel),
        .din (din),
        .y   (raw_bit)
    );

    assign dout = raw_bit & valid;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Scoreboard bench for mux4x1_rr_arbiter (default MAX_HOLD=8, CNT_W=3).
// Each stimulus cycle pushes the outputs expected during that cycle; a
// negedge monitor pops and compares them.
module tb_mux4x1_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       dout;
`ifdef RR_ARB_LOCK_EN
    logic       lock;
    logic       lock_req;
`endif

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       dout;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    mux4x1_rr_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
`ifdef RR_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {gnt,sel,valid,dout}=%b expected %b", name, act, exp);
        end
    endtask

    // One stimulus cycle: drive inputs just after the edge and record the
    // outputs expected for this cycle (registered from the previous edge).
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] d,
                       input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic ed, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        req   = rq;
        din   = d;
`ifdef RR_ARB_LOCK_EN
        lock  = lock_req;
`endif
        e.gnt   = eg;
        e.sel   = es;
        e.valid = ev;
        e.dout  = ed;
        e.tag   = tag;
        q.push_back(e);
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.tag, {gnt, sel, valid, dout}, {e.gnt, e.sel, e.valid, e.dout});
            end
        end
    end

    initial begin
        logic [3:0] d_rot;
        int         o;
        // NOTE: inputs are driven with blocking assignments away from the
        // clock edge so the DUT never races the bench.
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
`ifdef RR_ARB_LOCK_EN
        lock     = 1'b0;
        lock_req = 1'b0;
`endif

        // Reset state.
        cyc(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset0");
        cyc(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset1");

        // Single requester: one-cycle latency, data path, release to IDLE.
        cyc(1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 0, 0, "single_idle");
        cyc(1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, "single_grant");
        cyc(1, 4'b0100, 4'b1011, 4'b0100, 2'd2, 1, 0, "single_data0");
        cyc(1, 4'b0000, 4'b1011, 4'b0100, 2'd2, 1, 0, "single_drop");
        cyc(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "single_back_idle");

        // Reset mid-grant (owner 2), then all-request grants 0 (ptr cleared).
        cyc(1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 0, 0, "midrst_setup");
        cyc(1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, "midrst_owner2");
        cyc(0, 4'b1111, 4'b0100, 4'b0000, 2'd0, 0, 0, "midrst_same_cycle");
        cyc(0, 4'b1111, 4'b0100, 4'b0000, 2'd0, 0, 0, "midrst_hold");
        cyc(1, 4'b1111, 4'b1010, 4'b0000, 2'd0, 0, 0, "midrst_release");

        // Timeout rotation: 0,1,2,3,0, each exactly 8 cycles, no gaps.
        d_rot = 4'b1010;
        for (int g = 0; g < 5; g++) begin
            o = g % 4;
            for (int k = 0; k < 8; k++)
                cyc(1, 4'b1111, d_rot, 4'b0001 << o, 2'(o), 1, d_rot[o],
                    $sformatf("rotate_g%0d_c%0d", g, k));
        end

        // Early release: owner 1 drops after 3 cycles, requester 3 takes over.
        cyc(1, 4'b1010, 4'b1010, 4'b0010, 2'd1, 1, 1, "early_c0");
        cyc(1, 4'b1010, 4'b1010, 4'b0010, 2'd1, 1, 1, "early_c1");
        cyc(1, 4'b1000, 4'b1010, 4'b0010, 2'd1, 1, 1, "early_c2");
        cyc(1, 4'b0001, 4'b1010, 4'b1000, 2'd3, 1, 1, "early_switch");

        // Lone requester 0 through two timeouts: grant never drops.
        for (int k = 0; k < 20; k++)
            cyc(1, 4'b0001, 4'b1010, 4'b0001, 2'd0, 1, 0, $sformatf("lone_c%0d", k));
        cyc(1, 4'b0000, 4'b1010, 4'b0001, 2'd0, 1, 0, "lone_drop");
        cyc(1, 4'b0000, 4'b1010, 4'b0000, 2'd0, 0, 0, "lone_idle");

`ifdef RR_ARB_LOCK_EN
        // Lock: owner 0 keeps the grant past the timeout; unlock moves it to 1.
        lock_req = 1'b1;
        cyc(1, 4'b0001, 4'b1010, 4'b0000, 2'd0, 0, 0, "lock_setup");
        for (int k = 0; k < 20; k++)
            cyc(1, 4'b0011, 4'b1010, 4'b0001, 2'd0, 1, 0, $sformatf("lock_c%0d", k));
        lock_req = 1'b0;
        cyc(1, 4'b0011, 4'b1010, 4'b0001, 2'd0, 1, 0, "lock_fall");
        cyc(1, 4'b0011, 4'b1010, 4'b0010, 2'd1, 1, 1, "lock_moved");
        cyc(1, 4'b0000, 4'b1010, 4'b0010, 2'd1, 1, 1, "lock_drop");
        cyc(1, 4'b0000, 4'b1010, 4'b0000, 2'd0, 0, 0, "lock_idle");
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
